// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter slice: bus command
// encoding, tag-table entry layout and owner identifiers.
package mem_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int DATA_W   = 64;
  localparam int TAG_W    = 4;
  localparam int NUM_TAGS = 16;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_DC = 1'b0,
    OWNER_IC = 1'b1
  } MEM_ARB_OWNER;

  typedef struct packed {
    logic         valid;
    MEM_ARB_OWNER owner;
  } tag_entry_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/grant, memory bus and response-routing signals of the arbiter.
// slave: arbiter side; master: cache controllers plus memory side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              ev_req, dc_req, ic_req;
  logic [XLEN-1:0]   ev_addr, dc_addr, ic_addr;
  logic [DATA_W-1:0] ev_data;
  logic              ev_grant, dc_grant, ic_grant;

  BUS_COMMAND        arb2mem_command;
  logic [XLEN-1:0]   arb2mem_addr;
  logic [DATA_W-1:0] arb2mem_data;
  logic [TAG_W-1:0]  mem2arb_response;
  logic [TAG_W-1:0]  mem2arb_tag;
  logic [DATA_W-1:0] mem2arb_data;

  logic              dc_rsp_valid, ic_rsp_valid;
  logic [TAG_W-1:0]  rsp_tag;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  dc_outstanding, ic_outstanding;
  logic              arb_tag_err;

  modport slave (
    input  ev_req, dc_req, ic_req, ev_addr, dc_addr, ic_addr, ev_data,
    input  mem2arb_response, mem2arb_tag, mem2arb_data,
    output ev_grant, dc_grant, ic_grant,
    output arb2mem_command, arb2mem_addr, arb2mem_data,
    output dc_rsp_valid, ic_rsp_valid, rsp_tag, rsp_data,
    output dc_outstanding, ic_outstanding, arb_tag_err
  );

  modport master (
    output ev_req, dc_req, ic_req, ev_addr, dc_addr, ic_addr, ev_data,
    output mem2arb_response, mem2arb_tag, mem2arb_data,
    input  ev_grant, dc_grant, ic_grant,
    input  arb2mem_command, arb2mem_addr, arb2mem_data,
    input  dc_rsp_valid, ic_rsp_valid, rsp_tag, rsp_data,
    input  dc_outstanding, ic_outstanding, arb_tag_err
  );

endinterface

// File: rtl/mem_tag_table.sv
// Owner table for outstanding memory loads, indexed by memory tag.
// Free (data return) is applied before allocate (load grant) in the same
// cycle, so a tag can be returned and reissued on one edge. Keeps per-owner
// saturating outstanding counters and a sticky error for bad returns or
// overwrites of live entries.
module mem_tag_table #(
  parameter int NUM_TAGS = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          alloc_en,
  input  logic [3:0]                    alloc_tag,
  input  mem_arbiter_pkg::MEM_ARB_OWNER alloc_owner,
  input  logic [3:0]                    lookup_tag,
  output logic                          lookup_hit,
  output mem_arbiter_pkg::MEM_ARB_OWNER lookup_owner,
  output logic [3:0]                    dc_cnt,
  output logic [3:0]                    ic_cnt,
  output logic                          tag_err
);
  import mem_arbiter_pkg::*;

  localparam logic [TAG_W-1:0] CNT_MAX = TAG_W'(NUM_TAGS - 1);

  tag_entry_t tbl [NUM_TAGS];
  logic       miss_ret, overwrite;
  logic       dc_inc, dc_dec, ic_inc, ic_dec;

  function automatic logic [TAG_W-1:0] cnt_next(input logic [TAG_W-1:0] cnt,
                                                input logic inc, input logic dec);
    if (inc && !dec) return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    if (dec && !inc) return (cnt == '0) ? cnt : cnt - 1'b1;
    return cnt;
  endfunction

  assign lookup_hit   = (lookup_tag != '0) && tbl[lookup_tag].valid;
  assign lookup_owner = tbl[lookup_tag].owner;
  assign miss_ret     = (lookup_tag != '0) && !tbl[lookup_tag].valid;
  assign overwrite    = alloc_en && tbl[alloc_tag].valid &&
                        !(lookup_hit && (lookup_tag == alloc_tag));

  assign dc_inc = alloc_en && (alloc_owner == OWNER_DC);
  assign ic_inc = alloc_en && (alloc_owner == OWNER_IC);
  assign dc_dec = lookup_hit && (lookup_owner == OWNER_DC);
  assign ic_dec = lookup_hit && (lookup_owner == OWNER_IC);

  // Free the returning entry, then allocate the granted one (allocate wins)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) tbl[i] <= '0;
    end else begin
      if (lookup_hit) tbl[lookup_tag].valid <= 1'b0;
      if (alloc_en)   tbl[alloc_tag] <= '{valid: 1'b1, owner: alloc_owner};
    end
  end

  // Per-owner outstanding counters; simultaneous inc and dec cancel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dc_cnt <= '0;
      ic_cnt <= '0;
    end else begin
      dc_cnt <= cnt_next(dc_cnt, dc_inc, dc_dec);
      ic_cnt <= cnt_next(ic_cnt, ic_inc, ic_dec);
    end
  end

  // Sticky error: return on an empty tag or allocation over a live one
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      tag_err <= 1'b0;
    else if (miss_ret || overwrite) tag_err <= 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory bus arbiter for eviction stores, D-cache loads and I-cache loads.
// Fixed priority ev > dc > ic; a request is granted in the cycle memory
// returns a nonzero response tag. Load tags are tracked in mem_tag_table
// so data returns are routed to the issuing cache.
// Optional feature macro: MEM_ARB_ANTISTARVE_EN (I-cache starvation boost).
module mem_arbiter #(
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  import mem_arbiter_pkg::*;

  logic         active, accepted, boost;
  logic         sel_ev, sel_dc, sel_ic;
  logic         alloc_en, lookup_hit;
  MEM_ARB_OWNER alloc_owner, lookup_owner;

`ifdef MEM_ARB_ANTISTARVE_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_cnt;

  // Count consecutive cycles the I-cache is requesting but not granted
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          starve_cnt <= '0;
    else if (!bus.ic_req || bus.ic_grant) starve_cnt <= '0;
    else if (starve_cnt < STARVE_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  end

  assign boost = (starve_cnt >= STARVE_W'(STARVE_LIMIT));
`else
  assign boost = 1'b0;
`endif

  // The bus looks idle for as long as reset is held
  assign active   = !reset;
  assign sel_ev   = bus.ev_req;
  assign sel_ic   = !bus.ev_req && bus.ic_req && (!bus.dc_req || boost);
  assign sel_dc   = !bus.ev_req && bus.dc_req && !sel_ic;
  assign accepted = active && (bus.mem2arb_response != '0);

  assign bus.ev_grant = accepted && sel_ev;
  assign bus.dc_grant = accepted && sel_dc;
  assign bus.ic_grant = accepted && sel_ic;

  // Drive the memory bus from the selected requester
  always_comb begin
    bus.arb2mem_command = BUS_NONE;
    bus.arb2mem_addr    = '0;
    bus.arb2mem_data    = '0;
    if (active) begin
      if (sel_ev) begin
        bus.arb2mem_command = BUS_STORE;
        bus.arb2mem_addr    = bus.ev_addr;
        bus.arb2mem_data    = bus.ev_data;
      end else if (sel_dc) begin
        bus.arb2mem_command = BUS_LOAD;
        bus.arb2mem_addr    = bus.dc_addr;
      end else if (sel_ic) begin
        bus.arb2mem_command = BUS_LOAD;
        bus.arb2mem_addr    = bus.ic_addr;
      end
    end
  end

  assign alloc_en    = accepted && (sel_dc || sel_ic);
  assign alloc_owner = sel_ic ? OWNER_IC : OWNER_DC;

  mem_tag_table #(.NUM_TAGS(NUM_TAGS)) u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (alloc_en),
    .alloc_tag    (bus.mem2arb_response),
    .alloc_owner  (alloc_owner),
    .lookup_tag   (bus.mem2arb_tag),
    .lookup_hit   (lookup_hit),
    .lookup_owner (lookup_owner),
    .dc_cnt       (bus.dc_outstanding),
    .ic_cnt       (bus.ic_outstanding),
    .tag_err      (bus.arb_tag_err)
  );

  assign bus.dc_rsp_valid = active && lookup_hit && (lookup_owner == OWNER_DC);
  assign bus.ic_rsp_valid = active && lookup_hit && (lookup_owner == OWNER_IC);
  assign bus.rsp_tag      = bus.mem2arb_tag;
  assign bus.rsp_data     = bus.mem2arb_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: arbitration, tag routing, same-cycle
// free/allocate, starvation boost, bad-tag error and mid-flight reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  typedef struct packed {
    logic [3:0]  tag;
    logic        is_ic;
    logic [63:0] data;
  } rsp_t;
  rsp_t sb_q[$];

  mem_arbiter_if bus();

  mem_arbiter #(.NUM_TAGS(16), .STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic idle();
    bus.ev_req = 0; bus.dc_req = 0; bus.ic_req = 0;
    bus.ev_addr = '0; bus.dc_addr = '0; bus.ic_addr = '0; bus.ev_data = '0;
    bus.mem2arb_response = '0; bus.mem2arb_tag = '0; bus.mem2arb_data = '0;
  endtask

  // Present a data return and record what the arbiter must route
  task automatic drive_return(input logic [3:0] tag, input logic is_ic, input logic [63:0] data);
    bus.mem2arb_tag  = tag;
    bus.mem2arb_data = data;
    sb_q.push_back('{tag: tag, is_ic: is_ic, data: data});
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.arb2mem_command !== BUS_NONE || {bus.ev_grant, bus.dc_grant, bus.ic_grant} !== 3'b000) begin
      failures++; $display("FAIL reset_bus got cmd=%0d grants=%b exp cmd=0 grants=000", bus.arb2mem_command, {bus.ev_grant, bus.dc_grant, bus.ic_grant});
    end
    checks++;
    if ({bus.dc_outstanding, bus.ic_outstanding, bus.arb_tag_err, bus.dc_rsp_valid, bus.ic_rsp_valid} !== 11'h0) begin
      failures++; $display("FAIL reset_state got dc=%0d ic=%0d err=%b exp all 0", bus.dc_outstanding, bus.ic_outstanding, bus.arb_tag_err);
    end
    reset = 0;
    @(negedge clock);
  endtask

  task automatic test_store_priority();
    bus.ev_req = 1; bus.dc_req = 1; bus.ic_req = 1;
    bus.ev_addr = 32'h0000_0A00; bus.dc_addr = 32'h100; bus.ic_addr = 32'h200;
    bus.ev_data = 64'hCAFE_F00D_1234_5678; bus.mem2arb_response = 4'd3;
    #1;
    checks++;
    if (bus.arb2mem_command !== BUS_STORE || bus.arb2mem_addr !== 32'h0A00 || bus.arb2mem_data !== 64'hCAFE_F00D_1234_5678) begin
      failures++; $display("FAIL store_bus got cmd=%0d addr=%h data=%h exp cmd=2 addr=a00 data=cafef00d12345678", bus.arb2mem_command, bus.arb2mem_addr, bus.arb2mem_data);
    end
    checks++;
    if ({bus.ev_grant, bus.dc_grant, bus.ic_grant} !== 3'b100) begin
      failures++; $display("FAIL store_grants got=%b exp=100", {bus.ev_grant, bus.dc_grant, bus.ic_grant});
    end
    @(negedge clock);
    bus.mem2arb_response = 4'd0;
    #1;
    checks++;
    if (bus.ev_grant !== 1'b0 || bus.arb2mem_command !== BUS_STORE) begin
      failures++; $display("FAIL store_refused got grant=%b cmd=%0d exp grant=0 cmd=2", bus.ev_grant, bus.arb2mem_command);
    end
    @(negedge clock);
    idle();
    #1;
    checks++;
    if ({bus.dc_outstanding, bus.ic_outstanding, bus.arb_tag_err} !== 9'h0) begin
      failures++; $display("FAIL store_no_entry got dc=%0d ic=%0d err=%b exp 0 0 0", bus.dc_outstanding, bus.ic_outstanding, bus.arb_tag_err);
    end
    @(negedge clock);
  endtask

  task automatic test_dc_load_return();
    rsp_t e;
    bus.dc_req = 1; bus.dc_addr = 32'h100; bus.mem2arb_response = 4'd5;
    #1;
    checks++;
    if (bus.arb2mem_command !== BUS_LOAD || bus.arb2mem_addr !== 32'h100 || bus.arb2mem_data !== 64'h0 || bus.dc_grant !== 1'b1) begin
      failures++; $display("FAIL dc_load_bus got cmd=%0d addr=%h data=%h grant=%b exp 1 100 0 1", bus.arb2mem_command, bus.arb2mem_addr, bus.arb2mem_data, bus.dc_grant);
    end
    @(negedge clock);
    idle();
    #1;
    checks++;
    if (bus.dc_outstanding !== 4'd1) begin
      failures++; $display("FAIL dc_out_inc got=%0d exp=1", bus.dc_outstanding);
    end
    drive_return(4'd5, 1'b0, 64'hDEAD);
    #1;
    e = sb_q.pop_front();
    checks++;
    if ({bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, bus.rsp_data} !== {!e.is_ic, e.is_ic, e.tag, e.data}) begin
      failures++; $display("FAIL dc_return got v=%b%b tag=%0d data=%h exp v=%b%b tag=%0d data=%h", bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, bus.rsp_data, !e.is_ic, e.is_ic, e.tag, e.data);
    end
    @(negedge clock);
    idle();
    #1;
    checks++;
    if (bus.dc_outstanding !== 4'd0 || bus.arb_tag_err !== 1'b0) begin
      failures++; $display("FAIL dc_out_dec got dc=%0d err=%b exp 0 0", bus.dc_outstanding, bus.arb_tag_err);
    end
    @(negedge clock);
  endtask

  task automatic test_out_of_order();
    rsp_t e;
    bus.ic_req = 1; bus.ic_addr = 32'h200; bus.mem2arb_response = 4'd2;
    #1;
    checks++;
    if (bus.ic_grant !== 1'b1 || bus.arb2mem_command !== BUS_LOAD || bus.arb2mem_addr !== 32'h200) begin
      failures++; $display("FAIL ic_load got grant=%b cmd=%0d addr=%h exp 1 1 200", bus.ic_grant, bus.arb2mem_command, bus.arb2mem_addr);
    end
    @(negedge clock);
    idle();
    bus.dc_req = 1; bus.dc_addr = 32'h300; bus.mem2arb_response = 4'd7;
    @(negedge clock);
    idle();
    #1;
    checks++;
    if (bus.dc_outstanding !== 4'd1 || bus.ic_outstanding !== 4'd1) begin
      failures++; $display("FAIL ooo_counts got dc=%0d ic=%0d exp 1 1", bus.dc_outstanding, bus.ic_outstanding);
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive_return(4'd7, 1'b0, 64'h7777_0000_0000_0007);
      else        drive_return(4'd2, 1'b1, 64'h2222_0000_0000_0002);
      #1;
      e = sb_q.pop_front();
      checks++;
      if ({bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, bus.rsp_data} !== {!e.is_ic, e.is_ic, e.tag, e.data}) begin
        failures++; $display("FAIL ooo_return got v=%b%b tag=%0d data=%h exp v=%b%b tag=%0d data=%h", bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, bus.rsp_data, !e.is_ic, e.is_ic, e.tag, e.data);
      end
      @(negedge clock);
      idle();
    end
    #1;
    checks++;
    if (bus.dc_outstanding !== 4'd0 || bus.ic_outstanding !== 4'd0) begin
      failures++; $display("FAIL ooo_drain got dc=%0d ic=%0d exp 0 0", bus.dc_outstanding, bus.ic_outstanding);
    end
    @(negedge clock);
  endtask

  task automatic test_same_cycle();
    rsp_t e;
    bus.dc_req = 1; bus.mem2arb_response = 4'd4;
    @(negedge clock);
    idle();
    drive_return(4'd4, 1'b0, 64'h4444);
    bus.ic_req = 1; bus.mem2arb_response = 4'd4;
    #1;
    e = sb_q.pop_front();
    checks++;
    if ({bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, bus.rsp_data, bus.ic_grant} !== {!e.is_ic, e.is_ic, e.tag, e.data, 1'b1}) begin
      failures++; $display("FAIL same_tag_ret got v=%b%b tag=%0d grant=%b exp v=%b%b tag=%0d grant=1", bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, bus.ic_grant, !e.is_ic, e.is_ic, e.tag);
    end
    @(negedge clock);
    idle();
    #1;
    checks++;
    if ({bus.dc_outstanding, bus.ic_outstanding, bus.arb_tag_err} !== {4'd0, 4'd1, 1'b0}) begin
      failures++; $display("FAIL same_tag_counts got dc=%0d ic=%0d err=%b exp 0 1 0", bus.dc_outstanding, bus.ic_outstanding, bus.arb_tag_err);
    end
    drive_return(4'd4, 1'b1, 64'h4444_1C1C);
    #1;
    e = sb_q.pop_front();
    checks++;
    if ({bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, bus.rsp_data} !== {!e.is_ic, e.is_ic, e.tag, e.data}) begin
      failures++; $display("FAIL same_tag_new_owner got v=%b%b tag=%0d exp v=%b%b tag=%0d", bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, !e.is_ic, e.is_ic, e.tag);
    end
    @(negedge clock);
    idle();
    bus.dc_req = 1; bus.mem2arb_response = 4'd8;
    @(negedge clock);
    idle();
    drive_return(4'd8, 1'b0, 64'h8888);
    bus.dc_req = 1; bus.mem2arb_response = 4'd9;
    #1;
    e = sb_q.pop_front();
    checks++;
    if ({bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, bus.rsp_data} !== {!e.is_ic, e.is_ic, e.tag, e.data}) begin
      failures++; $display("FAIL same_owner_ret got v=%b%b tag=%0d exp v=%b%b tag=%0d", bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, !e.is_ic, e.is_ic, e.tag);
    end
    @(negedge clock);
    idle();
    #1;
    checks++;
    if (bus.dc_outstanding !== 4'd1 || bus.ic_outstanding !== 4'd0) begin
      failures++; $display("FAIL same_owner_count got dc=%0d ic=%0d exp 1 0", bus.dc_outstanding, bus.ic_outstanding);
    end
    drive_return(4'd9, 1'b0, 64'h9999);
    #1;
    e = sb_q.pop_front();
    checks++;
    if ({bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, bus.rsp_data} !== {!e.is_ic, e.is_ic, e.tag, e.data}) begin
      failures++; $display("FAIL same_owner_drain got v=%b%b tag=%0d exp v=%b%b tag=%0d", bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, !e.is_ic, e.is_ic, e.tag);
    end
    @(negedge clock);
    idle();
    #1;
    checks++;
    if ({bus.dc_outstanding, bus.ic_outstanding, bus.arb_tag_err} !== 9'h0) begin
      failures++; $display("FAIL same_cycle_end got dc=%0d ic=%0d err=%b exp 0 0 0", bus.dc_outstanding, bus.ic_outstanding, bus.arb_tag_err);
    end
    @(negedge clock);
  endtask

  task automatic test_antistarve();
    rsp_t e;
    logic exp_ic;
    logic own_ic [1:6];
    int   exp_dc_cnt = 0;
    int   exp_ic_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      bus.dc_req = 1; bus.ic_req = 1; bus.mem2arb_response = 4'(c);
      #1;
      exp_ic = 1'b0;
`ifdef MEM_ARB_ANTISTARVE_EN
      exp_ic = (c == 5);
`endif
      own_ic[c] = exp_ic;
      if (exp_ic) exp_ic_cnt++; else exp_dc_cnt++;
      checks++;
      if ({bus.dc_grant, bus.ic_grant} !== {!exp_ic, exp_ic}) begin
        failures++; $display("FAIL starve_cycle%0d got dc=%b ic=%b exp dc=%b ic=%b", c, bus.dc_grant, bus.ic_grant, !exp_ic, exp_ic);
      end
      @(negedge clock);
    end
    idle();
    #1;
    checks++;
    if (bus.dc_outstanding !== 4'(exp_dc_cnt) || bus.ic_outstanding !== 4'(exp_ic_cnt)) begin
      failures++; $display("FAIL starve_counts got dc=%0d ic=%0d exp %0d %0d", bus.dc_outstanding, bus.ic_outstanding, exp_dc_cnt, exp_ic_cnt);
    end
    for (int c = 1; c <= 6; c++) begin
      drive_return(4'(c), own_ic[c], 64'(c) * 64'h0101_0101);
      #1;
      e = sb_q.pop_front();
      checks++;
      if ({bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, bus.rsp_data} !== {!e.is_ic, e.is_ic, e.tag, e.data}) begin
        failures++; $display("FAIL starve_return%0d got v=%b%b tag=%0d exp v=%b%b tag=%0d", c, bus.dc_rsp_valid, bus.ic_rsp_valid, bus.rsp_tag, !e.is_ic, e.is_ic, e.tag);
      end
      @(negedge clock);
      idle();
    end
    #1;
    checks++;
    if ({bus.dc_outstanding, bus.ic_outstanding, bus.arb_tag_err} !== 9'h0) begin
      failures++; $display("FAIL starve_drain got dc=%0d ic=%0d err=%b exp 0 0 0", bus.dc_outstanding, bus.ic_outstanding, bus.arb_tag_err);
    end
    @(negedge clock);
  endtask

  task automatic test_bad_tag();
    bus.mem2arb_tag = 4'd9; bus.mem2arb_data = 64'hBAD;
    #1;
    checks++;
    if (bus.dc_rsp_valid !== 1'b0 || bus.ic_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL bad_tag_valid got v=%b%b exp v=00", bus.dc_rsp_valid, bus.ic_rsp_valid);
    end
    @(negedge clock);
    idle();
    #1;
    checks++;
    if (bus.arb_tag_err !== 1'b1) begin
      failures++; $display("FAIL bad_tag_err got=%b exp=1", bus.arb_tag_err);
    end
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (bus.arb_tag_err !== 1'b1) begin
      failures++; $display("FAIL bad_tag_sticky got=%b exp=1", bus.arb_tag_err);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_midflight();
    bus.dc_req = 1; bus.mem2arb_response = 4'd10;
    @(negedge clock);
    idle(); bus.ic_req = 1; bus.mem2arb_response = 4'd11;
    @(negedge clock);
    idle(); bus.dc_req = 1; bus.mem2arb_response = 4'd12;
    @(negedge clock);
    idle();
    #1;
    checks++;
    if (bus.dc_outstanding !== 4'd2 || bus.ic_outstanding !== 4'd1) begin
      failures++; $display("FAIL mid_counts got dc=%0d ic=%0d exp 2 1", bus.dc_outstanding, bus.ic_outstanding);
    end
    bus.dc_req = 1; bus.mem2arb_response = 4'd13;
    #2;
    reset = 1;
    #1;
    checks++;
    if ({bus.dc_outstanding, bus.ic_outstanding, bus.arb_tag_err} !== 9'h0) begin
      failures++; $display("FAIL mid_reset_state got dc=%0d ic=%0d err=%b exp 0 0 0", bus.dc_outstanding, bus.ic_outstanding, bus.arb_tag_err);
    end
    checks++;
    if (bus.arb2mem_command !== BUS_NONE || bus.dc_grant !== 1'b0) begin
      failures++; $display("FAIL mid_reset_bus got cmd=%0d grant=%b exp 0 0", bus.arb2mem_command, bus.dc_grant);
    end
    @(negedge clock);
    reset = 0;
    idle();
    #1;
    checks++;
    if (bus.dc_outstanding !== 4'd0) begin
      failures++; $display("FAIL mid_post_reset got dc=%0d exp 0", bus.dc_outstanding);
    end
    bus.mem2arb_tag = 4'd10; bus.mem2arb_data = 64'h0101;
    #1;
    checks++;
    if (bus.dc_rsp_valid !== 1'b0 || bus.ic_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL stale_tag_valid got v=%b%b exp v=00", bus.dc_rsp_valid, bus.ic_rsp_valid);
    end
    @(negedge clock);
    idle();
    #1;
    checks++;
    if (bus.arb_tag_err !== 1'b1) begin
      failures++; $display("FAIL stale_tag_err got=%b exp=1", bus.arb_tag_err);
    end
    @(negedge clock);
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clock);
    test_reset();
    test_store_priority();
    test_dc_load_return();
    test_out_of_order();
    test_same_cycle();
    test_antistarve();
    test_bad_tag();
    test_reset_midflight();
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing the single memory bus among three requesters: D-cache evictions (stores), D-cache miss loads, and I-cache miss loads. It holds requests under a valid/grant handshake and tracks outstanding load tags in an owner table. It routes each memory data return to the requester that issued it. It sits between the icache/dcache controllers and memory, replacing the combinational reject scheme.

## Interface
- NUM_TAGS, 16 — memory tag space; tag 0 means "no transaction".
- STARVE_LIMIT, 4 — consecutive denied cycles before I-cache priority boost.
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- ev_req / dc_req / ic_req  in  1 each  request valid; held stable until the matching grant
- ev_addr, dc_addr, ic_addr  in  `XLEN each  request address
- ev_data  in  64  eviction store data
- ev_grant / dc_grant / ic_grant  out  1 each  request accepted this cycle
- arb2mem_command  out  BUS_COMMAND  BUS_NONE / BUS_LOAD / BUS_STORE
- arb2mem_addr  out  `XLEN;  arb2mem_data  out  64
- mem2arb_response  in  4  nonzero = command accepted with this tag
- mem2arb_tag  in  4  nonzero = data return for this tag;  mem2arb_data  in  64
- dc_rsp_valid, ic_rsp_valid  out  1 each;  rsp_tag  out  4;  rsp_data  out  64
- dc_outstanding, ic_outstanding  out  4 each  live load counts
- arb_tag_err  out  1  sticky: return on a tag with no table entry

## Operation
- Priority: ev > dc > ic; boost (Configuration) places ic above dc, never above ev.
- Exactly one requester drives the bus per cycle. With no request: BUS_NONE, addr 0, data 0.
- arb2mem_data = ev_data only when ev is selected, else 0.
- Grant: selected requester's grant = (mem2arb_response != 0). Unselected grants are 0. A refused selection is retried next cycle.
- Load grant: table[response] <= {valid=1, owner=dc|ic} at the clock edge; the matching outstanding counter increments.
- Store grant: no table entry.
- Return when mem2arb_tag != 0 and table[tag].valid:
  - dc_rsp_valid or ic_rsp_valid asserted combinationally in the same cycle.
  - rsp_tag = tag, rsp_data = mem2arb_data.
  - Entry cleared and the owner's counter decremented at the edge.
- Return on an invalid entry: no rsp_valid; arb_tag_err sets and holds until reset.
- Same-cycle return and allocate of the same tag: free applies first, so the entry ends valid with the new owner and counters net correctly.
- Same-cycle return and allocate for the same owner with different tags: that owner's counter is unchanged.
- A new request is never blocked by outstanding loads; stall is the memory's refusal only.
- Allocation on a tag already valid: overwrite, and set arb_tag_err.

## Timing
- Request to bus is combinational, zero cycles. Grant is in the same cycle as the memory response.
- Table and counter updates are visible the cycle after the edge.
- Return routing is combinational, zero cycles.
- Reset (asynchronous, any time, including mid-transaction):
  - Table all invalid, counters 0, starve counter 0, arb_tag_err 0.
  - All grants, rsp_valid and command outputs reflect an idle bus (BUS_NONE).
  - In-flight tags are forgotten; returns after reset set arb_tag_err.
- Outstanding counters saturate at NUM_TAGS-1 and do not wrap below 0.

## Configuration
- MEM_ARB_ANTISTARVE_EN defined:
  - starve_cnt increments each cycle ic_req is high and ic_grant is low.
  - It clears on ic_grant or when ic_req is low.
  - When starve_cnt >= STARVE_LIMIT, ic outranks dc.
- Undefined: fixed ev > dc > ic; starve_cnt is not built.

## Structure
- Shared package: MEM_ARB_OWNER enum (OWNER_DC, OWNER_IC), tag-table entry struct {valid, owner}, NUM_TAGS constant.
- BUS_COMMAND comes from the existing headers.
- One natural sub-module, mem_tag_table: allocate port, free port, lookup port, and per-owner counters. Arbitration logic lives in mem_arbiter.

## Test plan
- ev_req=1, dc_req=1, ic_req=1, response=3 -> command BUS_STORE, ev_addr on bus, ev_grant=1 only; no table entry.
- dc_req at 0x100, response=5; later mem2arb_tag=5 with data 0xDEAD -> dc_rsp_valid=1, rsp_tag=5, dc_outstanding 1→0.
- ic load gets tag 2 and dc load gets tag 7; returns arrive 7 then 2 -> each routed to its owner, none misrouted.
- With MEM_ARB_ANTISTARVE_EN, STARVE_LIMIT=4: dc_req and ic_req held high with response nonzero -> dc granted 4 cycles, ic granted on the 5th cycle.
- mem2arb_tag=9 with no entry -> no rsp_valid, arb_tag_err=1 stays set.
- Reset asserted mid-flight with 3 loads outstanding -> counters 0 asynchronously, command BUS_NONE; a later return of an old tag sets arb_tag_err.
